fifo_sync_param: RTL and testbench
==================================

# fifo_sync_param

Single-clock, parametrised FIFO for intra-domain buffering between producer and consumer stages. It generalises the team's dual-clock Gray-pointer FIFO with the following additions:
- selectable read mode (registered or first-word-fall-through);
- occupancy count and programmable almost-full/almost-empty thresholds;
- synchronous flush;
- sticky overflow/underflow error flags.

No pointer synchronisers are needed because both sides share one clock.

## Interface
- DSIZE, 8, data width in bits (≥1)
- ASIZE, 4, address width; DEPTH = 1<<ASIZE entries
- AFULL_TH, DEPTH-2, almost-full threshold (1..DEPTH)
- AEMPTY_TH, 1, almost-empty threshold (0..DEPTH-1)
- FWFT, 0, read mode: 0 = registered read, 1 = first-word-fall-through
- clk  input  1  sole clock; all state updates on posedge clk
- rst  input  1  asynchronous, active-high reset
- flush  input  1  synchronous clear of FIFO contents
- winc  input  1  write request
- wdata  input  DSIZE  write data
- rinc  input  1  read request
- rdata  output  DSIZE  read data
- wfull  output  1  count == DEPTH
- rempty  output  1  count == 0
- almost_full  output  1  count ≥ AFULL_TH
- almost_empty  output  1  count ≤ AEMPTY_TH
- count  output  ASIZE+1  current occupancy, 0..DEPTH
- overflow  output  1  sticky: winc seen while wfull
- underflow  output  1  sticky: rinc seen while rempty

## Operation
- Write accepted (wr_en) = winc & ~wfull; read accepted (rd_en) = rinc & ~rempty.
- Pointers: ASIZE-bit binary wptr/rptr, wrapping DEPTH-1 → 0 naturally.
- Memory is addressed with the pointer directly.
- Occupancy is an explicit (ASIZE+1)-bit counter; there is no pointer-MSB comparison.
- count update:
  - +1 on wr_en only;
  - −1 on rd_en only;
  - unchanged when both or neither are active.
- Full and simultaneous winc+rinc: write rejected, read accepted, count → DEPTH-1, overflow set.
- Empty and simultaneous winc+rinc: read rejected, write accepted, count → 1, underflow set.
- FWFT=0:
  - rdata is a register loaded with mem[rptr] on rd_en;
  - rdata holds its value otherwise.
- FWFT=1:
  - rdata = mem[rptr] combinationally, valid whenever rempty=0;
  - rd_en pops the word and advances to the next.
- Flush (priority over winc/rinc in the same cycle):
  - wptr, rptr and count → 0; flags → empty state; overflow/underflow cleared;
  - rdata and memory contents unchanged.
- overflow and underflow stay set until rst or flush.
- Reset values: count 0, wptr/rptr 0, rempty 1, wfull 0, almost_empty 1, almost_full 0, overflow 0, underflow 0, rdata 0. Memory is not reset.
- rst asserted mid-operation clears all state immediately (asynchronous). Operation resumes on the first posedge clk after rst deasserts.

## Timing
- All flags and count are registered, computed from next-count. They reflect the occupancy after the same edge that performs the write/read: zero extra lag.
- Write-to-read latency:
  - FWFT=1: a word written at edge N is visible on rdata and rempty=0 after edge N.
  - FWFT=0: rempty=0 after edge N; rinc at edge N+1 yields the data on rdata after edge N+1.
- A write to an empty FIFO and a read in the same cycle: read rejected (rempty still 1 at that edge).
- Throughput: one write and one read per cycle sustained when neither full nor empty.

## Structure
- Shared package fifo_pkg:
  - DEPTH derivation (1<<ASIZE);
  - count-width constant;
  - FWFT mode localparams (MODE_REG=0, MODE_FWFT=1);
  - parameter-legality checks (AFULL_TH range, AEMPTY_TH range).
- Sub-module fifo_dpram: DSIZE×DEPTH dual-port array with synchronous write (we, waddr, wdata) and asynchronous read (raddr → rdata_comb). The top level holds pointers, counter, flags and the read-mode mux/register.

## Test plan
- Reset/idle: rst pulse, FWFT=0 → count 0, rempty 1, almost_empty 1, wfull 0, rdata 0, no errors.
- Fill and drain, DSIZE=8, ASIZE=4:
  - write 0x00..0x0F → wfull 1 after 16th write, almost_full 1 at count 14;
  - read all → data 0x00..0x0F in order, rempty 1 after last read.
- Boundary simultaneity:
  - at count 16, winc+rinc → count 15, overflow 1, read data 0x00;
  - at count 0, winc+rinc → count 1, underflow 1.
- FWFT=1: write 0xA5 at edge N → rdata 0xA5 and rempty 0 after edge N without rinc; rinc pops and rempty returns to 1.
- Wrap-around: 40 interleaved writes/reads holding count at 3 → data order preserved across pointer wrap, count stays 3.
- Flush and mid-run reset:
  - at count 9 with winc asserted, flush → count 0, rempty 1, overflow cleared, write ignored;
  - rst asserted mid-burst → all outputs at reset values before the next edge.

Source files
------------

// File: rtl/fifo_pkg.sv
// Shared constants and parameter helpers for the single-clock FIFO family.
package fifo_pkg;

   // Read-mode selectors for the FWFT parameter
   localparam int MODE_REG  = 0;
   localparam int MODE_FWFT = 1;

   // Number of storage entries for a given address width
   function automatic int depth_of(input int asize);
      return int'(32'd1 << asize);
   endfunction

   // Occupancy counter width: one extra bit so DEPTH itself is representable
   function automatic int count_width(input int asize);
      return asize + 32'sd1;
   endfunction

   // Almost-full threshold must lie in 1..DEPTH
   function automatic bit afull_th_ok(input int th, input int asize);
      return (th >= 32'sd1) && (th <= depth_of(asize));
   endfunction

   // Almost-empty threshold must lie in 0..DEPTH-1
   function automatic bit aempty_th_ok(input int th, input int asize);
      return (th >= 32'sd0) && (th <= depth_of(asize) - 32'sd1);
   endfunction

endpackage

// File: rtl/fifo_sync_param_if.sv
// Producer/consumer handshake bundle of the single-clock FIFO.
interface fifo_sync_param_if
   import fifo_pkg::*;
#(
   parameter int DSIZE = 8,
   parameter int ASIZE = 4
);
   logic                          flush;
   logic                          winc;
   logic [DSIZE-1:0]              wdata;
   logic                          rinc;
   logic [DSIZE-1:0]              rdata;
   logic                          wfull;
   logic                          rempty;
   logic                          almost_full;
   logic                          almost_empty;
   logic [count_width(ASIZE)-1:0] count;
   logic                          overflow;
   logic                          underflow;

   // Client side: drives requests, observes data and status
   modport master (
      output flush, winc, wdata, rinc,
      input  rdata, wfull, rempty, almost_full, almost_empty, count, overflow, underflow
   );

   // FIFO side: consumes requests, produces data and status
   modport slave (
      input  flush, winc, wdata, rinc,
      output rdata, wfull, rempty, almost_full, almost_empty, count, overflow, underflow
   );
endinterface

// File: rtl/fifo_dpram.sv
// Storage array: synchronous write port, asynchronous read port. Not reset.
module fifo_dpram
   import fifo_pkg::*;
#(
   parameter int DSIZE = 8,
   parameter int ASIZE = 4
) (
   input  logic             clk,
   input  logic             we,
   input  logic [ASIZE-1:0] waddr,
   input  logic [DSIZE-1:0] wdata,
   input  logic [ASIZE-1:0] raddr,
   output logic [DSIZE-1:0] rdata_comb
);
   localparam int DEPTH = depth_of(ASIZE);

   logic [DSIZE-1:0] mem_r [DEPTH];

   // Write port: store one word per accepted write
   always_ff @(posedge clk) begin
      if (we) begin
         mem_r[waddr] <= wdata;
      end
   end

   assign rdata_comb = mem_r[raddr];
endmodule

// File: rtl/fifo_sync_param.sv
// Single-clock parametrised FIFO: pointers, occupancy counter, registered
// flags, sticky error flags and selectable registered / fall-through read.
module fifo_sync_param
   import fifo_pkg::*;
#(
   parameter int DSIZE     = 8,
   parameter int ASIZE     = 4,
   parameter int AFULL_TH  = depth_of(ASIZE) - 2,
   parameter int AEMPTY_TH = 1,
   parameter int FWFT      = MODE_REG
) (
   input  logic              clk,
   input  logic              rst,
   fifo_sync_param_if.slave  bus
);
   localparam int CW = count_width(ASIZE);
   localparam logic [CW-1:0] DEPTH_C  = CW'(depth_of(ASIZE));
   localparam logic [CW-1:0] AFULL_C  = CW'(AFULL_TH);
   localparam logic [CW-1:0] AEMPTY_C = CW'(AEMPTY_TH);
   localparam logic [CW-1:0] ONE_C    = CW'(1);

   if (!afull_th_ok(AFULL_TH, ASIZE)) begin : g_bad_afull
      $error("fifo_sync_param: AFULL_TH out of range 1..DEPTH");
   end
   if (!aempty_th_ok(AEMPTY_TH, ASIZE)) begin : g_bad_aempty
      $error("fifo_sync_param: AEMPTY_TH out of range 0..DEPTH-1");
   end

   logic [ASIZE-1:0] wptr_r, rptr_r;
   logic [CW-1:0]    count_r, count_nxt_s;
   logic             wfull_r, rempty_r, afull_r, aempty_r;
   logic             overflow_r, underflow_r;
   logic             wr_en_s, rd_en_s;
   logic [DSIZE-1:0] rdata_comb_s;

   assign wr_en_s = bus.winc & ~wfull_r;
   assign rd_en_s = bus.rinc & ~rempty_r;

   // Next occupancy: simultaneous accepted write and read cancel out
   always_comb begin
      count_nxt_s = count_r;
      case ({wr_en_s, rd_en_s})
         2'b10:   count_nxt_s = count_r + ONE_C;
         2'b01:   count_nxt_s = count_r - ONE_C;
         default: count_nxt_s = count_r;
      endcase
   end

   // Pointers, counter and flags; flush wins over any request in the same cycle
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wptr_r      <= {ASIZE{1'b0}};
         rptr_r      <= {ASIZE{1'b0}};
         count_r     <= {CW{1'b0}};
         wfull_r     <= 1'b0;
         rempty_r    <= 1'b1;
         afull_r     <= 1'b0;
         aempty_r    <= 1'b1;
         overflow_r  <= 1'b0;
         underflow_r <= 1'b0;
      end else if (bus.flush) begin
         wptr_r      <= {ASIZE{1'b0}};
         rptr_r      <= {ASIZE{1'b0}};
         count_r     <= {CW{1'b0}};
         wfull_r     <= 1'b0;
         rempty_r    <= 1'b1;
         afull_r     <= 1'b0;
         aempty_r    <= 1'b1;
         overflow_r  <= 1'b0;
         underflow_r <= 1'b0;
      end else begin
         if (wr_en_s) begin
            wptr_r <= wptr_r + {{(ASIZE-1){1'b0}}, 1'b1};
         end
         if (rd_en_s) begin
            rptr_r <= rptr_r + {{(ASIZE-1){1'b0}}, 1'b1};
         end
         count_r     <= count_nxt_s;
         wfull_r     <= (count_nxt_s == DEPTH_C);
         rempty_r    <= (count_nxt_s == {CW{1'b0}});
         afull_r     <= (count_nxt_s >= AFULL_C);
         aempty_r    <= (count_nxt_s <= AEMPTY_C);
         overflow_r  <= overflow_r  | (bus.winc & wfull_r);
         underflow_r <= underflow_r | (bus.rinc & rempty_r);
      end
   end

   fifo_dpram #(
      .DSIZE (DSIZE),
      .ASIZE (ASIZE)
   ) u_ram (
      .clk        (clk),
      .we         (wr_en_s & ~bus.flush),
      .waddr      (wptr_r),
      .wdata      (bus.wdata),
      .raddr      (rptr_r),
      .rdata_comb (rdata_comb_s)
   );

   if (FWFT == MODE_REG) begin : g_reg_read
      logic [DSIZE-1:0] rdata_r;

      // Registered read: capture the head word only when a read is accepted
      always_ff @(posedge clk or posedge rst) begin
         if (rst) begin
            rdata_r <= {DSIZE{1'b0}};
         end else if (rd_en_s && !bus.flush) begin
            rdata_r <= rdata_comb_s;
         end
      end

      assign bus.rdata = rdata_r;
   end else begin : g_fwft_read
      assign bus.rdata = rdata_comb_s;
   end

   assign bus.count        = count_r;
   assign bus.wfull        = wfull_r;
   assign bus.rempty       = rempty_r;
   assign bus.almost_full  = afull_r;
   assign bus.almost_empty = aempty_r;
   assign bus.overflow     = overflow_r;
   assign bus.underflow    = underflow_r;
endmodule

// File: tb/tb_fifo_sync_param.sv
// Directed self-checking bench for fifo_sync_param (registered and FWFT modes).
module tb_fifo_sync_param;
   logic clk = 1'b0;
   logic rst;
   int   checks = 0;
   int   errors = 0;

   always #5 clk = ~clk;

   fifo_sync_param_if #(.DSIZE(8), .ASIZE(4)) bus0 ();
   fifo_sync_param_if #(.DSIZE(8), .ASIZE(4)) bus1 ();

   fifo_sync_param #(.DSIZE(8), .ASIZE(4), .AFULL_TH(14), .AEMPTY_TH(1), .FWFT(0))
      dut0 (.clk(clk), .rst(rst), .bus(bus0));
   fifo_sync_param #(.DSIZE(8), .ASIZE(4), .AFULL_TH(14), .AEMPTY_TH(1), .FWFT(1))
      dut1 (.clk(clk), .rst(rst), .bus(bus1));

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst = 1'b1;
      bus0.flush = 1'b0; bus0.winc = 1'b0; bus0.wdata = 8'h00; bus0.rinc = 1'b0;
      bus1.flush = 1'b0; bus1.winc = 1'b0; bus1.wdata = 8'h00; bus1.rinc = 1'b0;
      #12;
      check_eq("rst_count",  32'(bus0.count), 32'd0);
      check_eq("rst_rempty", 32'(bus0.rempty), 32'd1);
      check_eq("rst_aempty", 32'(bus0.almost_empty), 32'd1);
      check_eq("rst_wfull",  32'(bus0.wfull), 32'd0);
      check_eq("rst_afull",  32'(bus0.almost_full), 32'd0);
      check_eq("rst_rdata",  32'(bus0.rdata), 32'd0);
      check_eq("rst_ovf",    32'(bus0.overflow), 32'd0);
      check_eq("rst_unf",    32'(bus0.underflow), 32'd0);
      rst = 1'b0;

      // FWFT: written word visible right after the write edge
      bus1.winc = 1'b1; bus1.wdata = 8'hA5;
      step();
      bus1.winc = 1'b0;
      check_eq("fwft_rdata",  32'(bus1.rdata), 32'hA5);
      check_eq("fwft_rempty", 32'(bus1.rempty), 32'd0);
      check_eq("fwft_count",  32'(bus1.count), 32'd1);
      bus1.rinc = 1'b1;
      step();
      bus1.rinc = 1'b0;
      check_eq("fwft_pop_rempty", 32'(bus1.rempty), 32'd1);
      check_eq("fwft_pop_count",  32'(bus1.count), 32'd0);

      // Fill 0x00..0x0F
      for (int i = 0; i < 16; i++) begin
         bus0.winc = 1'b1; bus0.wdata = 8'(i);
         step();
         check_eq("fill_count", 32'(bus0.count), 32'(i + 1));
         check_eq("fill_afull", 32'(bus0.almost_full), (i + 1 >= 14) ? 32'd1 : 32'd0);
         check_eq("fill_wfull", 32'(bus0.wfull), (i + 1 == 16) ? 32'd1 : 32'd0);
         check_eq("fill_aempty", 32'(bus0.almost_empty), (i + 1 <= 1) ? 32'd1 : 32'd0);
         check_eq("fill_rempty", 32'(bus0.rempty), 32'd0);
      end

      // Full with winc+rinc: write rejected, read accepted
      bus0.winc = 1'b1; bus0.rinc = 1'b1; bus0.wdata = 8'hEE;
      step();
      check_eq("full_both_count", 32'(bus0.count), 32'd15);
      check_eq("full_both_ovf",   32'(bus0.overflow), 32'd1);
      check_eq("full_both_rdata", 32'(bus0.rdata), 32'h00);
      check_eq("full_both_wfull", 32'(bus0.wfull), 32'd0);

      // Drain remaining 15 words in order
      bus0.winc = 1'b0;
      for (int i = 1; i < 16; i++) begin
         step();
         check_eq("drain_rdata", 32'(bus0.rdata), 32'(i));
         check_eq("drain_count", 32'(bus0.count), 32'(15 - i));
      end
      bus0.rinc = 1'b0;
      check_eq("drain_rempty", 32'(bus0.rempty), 32'd1);

      // Empty with winc+rinc: read rejected, write accepted
      bus0.winc = 1'b1; bus0.rinc = 1'b1; bus0.wdata = 8'h3C;
      step();
      check_eq("empty_both_count", 32'(bus0.count), 32'd1);
      check_eq("empty_both_unf",   32'(bus0.underflow), 32'd1);
      check_eq("empty_both_rdata", 32'(bus0.rdata), 32'h0F);
      check_eq("ovf_sticky",       32'(bus0.overflow), 32'd1);
      bus0.winc = 1'b0;
      step();
      bus0.rinc = 1'b0;
      check_eq("read_3c_rdata", 32'(bus0.rdata), 32'h3C);
      check_eq("read_3c_count", 32'(bus0.count), 32'd0);

      // Flush clears sticky flags, keeps rdata
      bus0.flush = 1'b1;
      step();
      bus0.flush = 1'b0;
      check_eq("flush1_ovf",   32'(bus0.overflow), 32'd0);
      check_eq("flush1_unf",   32'(bus0.underflow), 32'd0);
      check_eq("flush1_rdata", 32'(bus0.rdata), 32'h3C);

      // Wrap-around at steady count 3
      for (int i = 0; i < 3; i++) begin
         bus0.winc = 1'b1; bus0.wdata = 8'(8'h40 + i);
         step();
      end
      bus0.rinc = 1'b1;
      for (int k = 0; k < 40; k++) begin
         bus0.wdata = 8'(8'h43 + k);
         step();
         check_eq("wrap_rdata", 32'(bus0.rdata), 32'(8'h40 + k));
         check_eq("wrap_count", 32'(bus0.count), 32'd3);
      end
      bus0.winc = 1'b0; bus0.rinc = 1'b0;

      // Flush at count 9 with winc asserted and overflow set
      bus0.flush = 1'b1;
      step();
      bus0.flush = 1'b0;
      for (int i = 0; i < 17; i++) begin
         bus0.winc = 1'b1; bus0.wdata = 8'(8'h10 + i);
         step();
      end
      bus0.winc = 1'b0;
      check_eq("prefl_ovf", 32'(bus0.overflow), 32'd1);
      bus0.rinc = 1'b1;
      for (int i = 0; i < 7; i++) step();
      bus0.rinc = 1'b0;
      check_eq("prefl_count", 32'(bus0.count), 32'd9);
      check_eq("prefl_rdata", 32'(bus0.rdata), 32'h16);
      bus0.flush = 1'b1; bus0.winc = 1'b1; bus0.wdata = 8'h99;
      step();
      bus0.flush = 1'b0; bus0.winc = 1'b0;
      check_eq("flush_count",  32'(bus0.count), 32'd0);
      check_eq("flush_rempty", 32'(bus0.rempty), 32'd1);
      check_eq("flush_ovf",    32'(bus0.overflow), 32'd0);
      check_eq("flush_wfull",  32'(bus0.wfull), 32'd0);
      check_eq("flush_aempty", 32'(bus0.almost_empty), 32'd1);
      check_eq("flush_rdata",  32'(bus0.rdata), 32'h16);
      bus0.winc = 1'b1; bus0.wdata = 8'h55;
      step();
      bus0.winc = 1'b0; bus0.rinc = 1'b1;
      step();
      bus0.rinc = 1'b0;
      check_eq("post_flush_rdata", 32'(bus0.rdata), 32'h55);
      check_eq("post_flush_count", 32'(bus0.count), 32'd0);

      // Asynchronous reset in the middle of a write burst
      bus0.winc = 1'b1;
      for (int i = 0; i < 5; i++) begin
         bus0.wdata = 8'(8'h60 + i);
         step();
      end
      check_eq("burst_count", 32'(bus0.count), 32'd5);
      #3;
      rst = 1'b1;
      #1;
      check_eq("arst_count",  32'(bus0.count), 32'd0);
      check_eq("arst_rempty", 32'(bus0.rempty), 32'd1);
      check_eq("arst_wfull",  32'(bus0.wfull), 32'd0);
      check_eq("arst_aempty", 32'(bus0.almost_empty), 32'd1);
      check_eq("arst_afull",  32'(bus0.almost_full), 32'd0);
      check_eq("arst_rdata",  32'(bus0.rdata), 32'd0);
      #1;
      rst = 1'b0;
      bus0.wdata = 8'h77;
      step();
      bus0.winc = 1'b0;
      check_eq("resume_count", 32'(bus0.count), 32'd1);
      bus0.rinc = 1'b1;
      step();
      bus0.rinc = 1'b0;
      check_eq("resume_rdata", 32'(bus0.rdata), 32'h77);
      check_eq("resume_empty", 32'(bus0.rempty), 32'd1);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
